// File: rtl/vesa_timing_monitor.sv
// Measures the timing seen on hsync/vsync/de and declares lock after LOCK_FRAMES identical frames.
// Optional feature: define VTM_ERR_COUNT_EN to add the saturating err_count output.
module vesa_timing_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter bit          HS_POL      = 1'b1,
   parameter bit          VS_POL      = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             de,
   output logic [CNT_W-1:0] meas_h_total,
   output logic [CNT_W-1:0] meas_h_active,
   output logic [CNT_W-1:0] meas_hs_width,
   output logic [CNT_W-1:0] meas_v_total,
   output logic [CNT_W-1:0] meas_v_active,
   output logic [CNT_W-1:0] meas_vs_width,
   output logic             meas_valid,
   output logic             locked,
   output logic             timing_err,
   output logic [15:0]      frame_cnt
`ifdef VTM_ERR_COUNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   typedef enum logic [1:0] {ST_SEARCH, ST_ACQ, ST_LOCKED} state_t;

   localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   state_t           r_state;
   logic             r_hs_a, r_vs_a, r_de, r_hs_d, r_vs_d;
   logic [CNT_W-1:0] r_h_cnt, r_de_cnt, r_hsw_cnt;
   logic [CNT_W-1:0] r_last_ht, r_last_ha, r_last_hsw;
   logic [CNT_W-1:0] r_v_cnt, r_va_cnt, r_vsw_cnt;
   logic [3:0]       r_match;
   logic             r_have_ref;

   logic             w_hs_edge, w_vs_edge, w_hs_fall, w_line_de, w_wdog;
   logic             w_same, w_line_bad;
   logic [CNT_W-1:0] w_ht, w_ha, w_va;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_a <= 1'b0;
         r_vs_a <= 1'b0;
         r_de   <= 1'b0;
         r_hs_d <= 1'b0;
         r_vs_d <= 1'b0;
      end else begin
         r_hs_a <= (hsync == HS_POL);
         r_vs_a <= (vsync == VS_POL);
         r_de   <= de;
         r_hs_d <= r_hs_a;
         r_vs_d <= r_vs_a;
      end
   end

   // A line start coinciding with a frame start first closes the old line into the closing frame
   always_comb begin
      w_hs_edge  = r_hs_a & ~r_hs_d;
      w_vs_edge  = r_vs_a & ~r_vs_d;
      w_hs_fall  = ~r_hs_a & r_hs_d;
      w_line_de  = (r_de_cnt != '0);
      w_wdog     = ((r_h_cnt == '1) & ~w_hs_edge) | ((r_v_cnt == '1) & ~w_vs_edge);
      w_ht       = w_hs_edge ? r_h_cnt : r_last_ht;
      w_ha       = (w_hs_edge && w_line_de) ? r_de_cnt : r_last_ha;
      w_va       = (w_hs_edge && w_line_de) ? sat_inc(r_va_cnt) : r_va_cnt;
      w_same     = (w_ht == meas_h_total) && (w_ha == meas_h_active) &&
                   (r_last_hsw == meas_hs_width) && (r_v_cnt == meas_v_total) &&
                   (w_va == meas_v_active) && (r_vsw_cnt == meas_vs_width);
      w_line_bad = w_hs_edge && (r_h_cnt != meas_h_total);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt    <= '0;
         r_de_cnt   <= '0;
         r_hsw_cnt  <= '0;
         r_last_ht  <= '0;
         r_last_ha  <= '0;
         r_last_hsw <= '0;
         r_v_cnt    <= '0;
         r_va_cnt   <= '0;
         r_vsw_cnt  <= '0;
      end else begin
         r_h_cnt   <= w_hs_edge ? ONE : sat_inc(r_h_cnt);
         r_hsw_cnt <= w_hs_edge ? ONE : (r_hs_a ? sat_inc(r_hsw_cnt) : r_hsw_cnt);
         if (w_hs_edge)
            r_de_cnt <= r_de ? ONE : '0;
         else if (r_de)
            r_de_cnt <= sat_inc(r_de_cnt);
         if (w_hs_fall)
            r_last_hsw <= r_hsw_cnt;
         if (w_hs_edge)
            r_last_ht <= r_h_cnt;
         if (w_hs_edge && w_line_de)
            r_last_ha <= r_de_cnt;

         if (w_vs_edge) begin
            r_v_cnt   <= w_hs_edge ? ONE : '0;
            r_va_cnt  <= '0;
            r_vsw_cnt <= w_hs_edge ? ONE : '0;
         end else if (w_hs_edge) begin
            r_v_cnt  <= sat_inc(r_v_cnt);
            r_va_cnt <= w_va;
            if (r_vs_a)
               r_vsw_cnt <= sat_inc(r_vsw_cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_SEARCH;
         r_match       <= '0;
         r_have_ref    <= 1'b0;
         meas_h_total  <= '0;
         meas_h_active <= '0;
         meas_hs_width <= '0;
         meas_v_total  <= '0;
         meas_v_active <= '0;
         meas_vs_width <= '0;
         meas_valid    <= 1'b0;
         locked        <= 1'b0;
         timing_err    <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         meas_valid <= 1'b0;
         timing_err <= 1'b0;
         if (r_state != ST_SEARCH && w_vs_edge && !w_wdog) begin
            meas_h_total  <= w_ht;
            meas_h_active <= w_ha;
            meas_hs_width <= r_last_hsw;
            meas_v_total  <= r_v_cnt;
            meas_v_active <= w_va;
            meas_vs_width <= r_vsw_cnt;
            meas_valid    <= 1'b1;
            frame_cnt     <= frame_cnt + 16'd1;
         end
         case (r_state)
            ST_SEARCH: begin
               if (w_vs_edge) begin
                  r_state    <= ST_ACQ;
                  r_match    <= '0;
                  r_have_ref <= 1'b0;
               end
            end
            ST_ACQ: begin
               if (w_wdog) begin
                  r_state <= ST_SEARCH;
                  locked  <= 1'b0;
               end else if (w_vs_edge) begin
                  if (!r_have_ref) begin
                     r_have_ref <= 1'b1;
                     r_match    <= '0;
                  end else if (w_same) begin
                     r_match <= r_match + 4'd1;
                     if (r_match + 4'd1 == LOCK_N) begin
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
                     end
                  end else begin
                     r_match <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (w_wdog) begin
                  r_state    <= ST_SEARCH;
                  locked     <= 1'b0;
                  timing_err <= 1'b1;
               end else if (w_line_bad || (w_vs_edge && !w_same)) begin
                  // a frame closed in this cycle becomes the reference; otherwise the next close does
                  r_state    <= ST_ACQ;
                  locked     <= 1'b0;
                  timing_err <= 1'b1;
                  r_match    <= '0;
                  r_have_ref <= w_vs_edge;
               end
            end
            default: r_state <= ST_SEARCH;
         endcase
      end
   end

`ifdef VTM_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (timing_err && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vesa_timing_monitor.sv
// Directed bench: instance A uses default polarity/width, instance B inverted polarity with 8-bit counters.
module tb_vesa_timing_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, hs_act, vs_act, de_p;
   logic a_hs, a_vs, b_hs, b_vs;
   assign a_hs = hs_act;
   assign a_vs = ~vs_act;
   assign b_hs = ~hs_act;
   assign b_vs = vs_act;

   logic [15:0] a_ht, a_ha, a_hsw, a_vt, a_va, a_vsw, a_fc;
   logic        a_valid, a_locked, a_te;
   logic [7:0]  b_ht, b_ha, b_hsw, b_vt, b_va, b_vsw;
   logic [15:0] b_fc;
   logic        b_valid, b_locked, b_te;
`ifdef VTM_ERR_COUNT_EN
   logic [15:0] a_ec, b_ec;
`endif

   vesa_timing_monitor #(.CNT_W(16), .HS_POL(1'b1), .VS_POL(1'b0), .LOCK_FRAMES(2)) u_a (
      .clk(clk),
`ifdef VTM_ERR_COUNT_EN
      .err_count(a_ec),
`endif
      .rst(rst), .hsync(a_hs), .vsync(a_vs), .de(de_p),
      .meas_h_total(a_ht), .meas_h_active(a_ha), .meas_hs_width(a_hsw),
      .meas_v_total(a_vt), .meas_v_active(a_va), .meas_vs_width(a_vsw),
      .meas_valid(a_valid), .locked(a_locked), .timing_err(a_te), .frame_cnt(a_fc));

   vesa_timing_monitor #(.CNT_W(8), .HS_POL(1'b0), .VS_POL(1'b1), .LOCK_FRAMES(2)) u_b (
      .clk(clk),
`ifdef VTM_ERR_COUNT_EN
      .err_count(b_ec),
`endif
      .rst(rst), .hsync(b_hs), .vsync(b_vs), .de(de_p),
      .meas_h_total(b_ht), .meas_h_active(b_ha), .meas_hs_width(b_hsw),
      .meas_v_total(b_vt), .meas_v_active(b_va), .meas_vs_width(b_vsw),
      .meas_valid(b_valid), .locked(b_locked), .timing_err(b_te), .frame_cnt(b_fc));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int a_mv_n = 0, a_mv_last = 0, a_te_n = 0, a_te_last = 0, a_lk_cyc = 0;
   int b_te_n = 0, b_te_last = 0, b_lk_cyc = 0;
   logic a_lk_prev = 1'b0, b_lk_prev = 1'b0;
   always @(negedge clk) begin
      if (a_valid === 1'b1) begin a_mv_n++; a_mv_last = cyc; end
      if (a_te === 1'b1) begin a_te_n++; a_te_last = cyc; end
      if (b_te === 1'b1) begin b_te_n++; b_te_last = cyc; end
      if (a_locked === 1'b1 && !a_lk_prev) a_lk_cyc = cyc;
      if (b_locked === 1'b1 && !b_lk_prev) b_lk_cyc = cyc;
      a_lk_prev = (a_locked === 1'b1);
      b_lk_prev = (b_locked === 1'b1);
   end

   int fs[0:63];
   int l1[0:63];
   int fs_n = 0, gl_cyc = 0, end_cyc = 0;
   int pass_n = 0, tot_n = 0;

   task automatic gen_frame(input int ht, input int hsw, input int hd0, input int ha,
                            input int vt, input int vsw, input int vd0, input int va, input int gl);
      for (int l = 0; l < vt; l++) begin
         int len;
         len = (l == gl) ? ht + 1 : ht;
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            hs_act = (c < hsw);
            vs_act = (l < vsw);
            de_p   = (l >= vd0) && (l < vd0 + va) && (c >= hd0) && (c < hd0 + ha);
            if (c == 0 && l == 0) begin fs[fs_n] = cyc; fs_n++; end
            if (c == 0 && l == 1) l1[fs_n-1] = cyc;
            if (c == 0 && gl >= 0 && l == gl + 1) gl_cyc = cyc;
            end_cyc = cyc;
         end
      end
   endtask

   task automatic frame_t1();
      gen_frame(64, 8, 10, 48, 12, 2, 3, 8, -1);
   endtask

   task automatic frame_t2(input int gl);
      gen_frame(120, 12, 16, 100, 16, 3, 5, 10, gl);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         hs_act = 1'b0; vs_act = 1'b0; de_p = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      tot_n++; if ({a_ht, a_ha, a_hsw, a_vt, a_va, a_vsw, a_valid, a_locked, a_te, a_fc} !== '0)
         $display("FAIL reset_a: got %h expected 0", {a_ht, a_ha, a_hsw, a_vt, a_va, a_vsw, a_valid, a_locked, a_te, a_fc}); else pass_n++;
      tot_n++; if ({b_ht, b_ha, b_hsw, b_vt, b_va, b_vsw, b_valid, b_locked, b_te, b_fc} !== '0)
         $display("FAIL reset_b: got %h expected 0", {b_ht, b_ha, b_hsw, b_vt, b_va, b_vsw, b_valid, b_locked, b_te, b_fc}); else pass_n++;
      rst = 1'b0;
      idle(3);
   endtask

   task automatic test_rb();
      int base, mv0, te0;
      base = fs_n; mv0 = a_mv_n; te0 = a_te_n;
      for (int f = 0; f < 5; f++) frame_t1();
      idle(4);
      tot_n++; if (a_lk_cyc !== fs[base+3] + 2) $display("FAIL rb_lock_time: got %0d expected %0d", a_lk_cyc, fs[base+3] + 2); else pass_n++;
      tot_n++; if (a_mv_n - mv0 !== 4) $display("FAIL rb_mv_count: got %0d expected 4", a_mv_n - mv0); else pass_n++;
      tot_n++; if (a_mv_last !== fs[base+4] + 2) $display("FAIL rb_mv_time: got %0d expected %0d", a_mv_last, fs[base+4] + 2); else pass_n++;
      tot_n++; if (a_ht !== 16'd64) $display("FAIL rb_h_total: got %0d expected 64", a_ht); else pass_n++;
      tot_n++; if (a_ha !== 16'd48) $display("FAIL rb_h_active: got %0d expected 48", a_ha); else pass_n++;
      tot_n++; if (a_hsw !== 16'd8) $display("FAIL rb_hs_width: got %0d expected 8", a_hsw); else pass_n++;
      tot_n++; if (a_vt !== 16'd12) $display("FAIL rb_v_total: got %0d expected 12", a_vt); else pass_n++;
      tot_n++; if (a_va !== 16'd8) $display("FAIL rb_v_active: got %0d expected 8", a_va); else pass_n++;
      tot_n++; if (a_vsw !== 16'd2) $display("FAIL rb_vs_width: got %0d expected 2", a_vsw); else pass_n++;
      tot_n++; if (a_fc !== 16'd4) $display("FAIL rb_frame_cnt: got %0d expected 4", a_fc); else pass_n++;
      tot_n++; if (a_te_n - te0 !== 0) $display("FAIL rb_no_err: got %0d expected 0", a_te_n - te0); else pass_n++;
   endtask

   task automatic test_reset_mid();
      int base, mv0;
      tot_n++; if (a_locked !== 1'b1) $display("FAIL rm_locked_before: got %0d expected 1", a_locked); else pass_n++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tot_n++; if ({a_ht, a_ha, a_hsw, a_vt, a_va, a_vsw, a_valid, a_locked, a_te} !== '0)
         $display("FAIL rm_outputs: got %h expected 0", {a_ht, a_ha, a_hsw, a_vt, a_va, a_vsw, a_valid, a_locked, a_te}); else pass_n++;
      tot_n++; if (a_fc !== 16'd0) $display("FAIL rm_frame_cnt: got %0d expected 0", a_fc); else pass_n++;
      rst = 1'b0;
      idle(5);
      base = fs_n; mv0 = a_mv_n;
      frame_t2(-1);
      frame_t2(-1);
      tot_n++; if (a_mv_n - mv0 !== 1) $display("FAIL rm_mv_count: got %0d expected 1", a_mv_n - mv0); else pass_n++;
      tot_n++; if (a_mv_last !== fs[base+1] + 2) $display("FAIL rm_first_mv: got %0d expected %0d", a_mv_last, fs[base+1] + 2); else pass_n++;
      frame_t2(-1);
      frame_t2(-1);
      tot_n++; if (a_lk_cyc !== fs[base+3] + 2) $display("FAIL rm_lock_time: got %0d expected %0d", a_lk_cyc, fs[base+3] + 2); else pass_n++;
   endtask

   task automatic test_glitch();
      int gb, ta0, tb0;
      tot_n++; if (b_locked !== 1'b1) $display("FAIL pol_locked: got %0d expected 1", b_locked); else pass_n++;
      tot_n++; if (a_ht !== 16'd120) $display("FAIL small_h_total: got %0d expected 120", a_ht); else pass_n++;
      tot_n++; if (b_ht !== 8'd120) $display("FAIL pol_h_total: got %0d expected 120", b_ht); else pass_n++;
      tot_n++; if (b_ha !== 8'd100) $display("FAIL pol_h_active: got %0d expected 100", b_ha); else pass_n++;
      tot_n++; if (b_hsw !== 8'd12) $display("FAIL pol_hs_width: got %0d expected 12", b_hsw); else pass_n++;
      tot_n++; if (b_vt !== 8'd16) $display("FAIL pol_v_total: got %0d expected 16", b_vt); else pass_n++;
      tot_n++; if (b_va !== 8'd10) $display("FAIL pol_v_active: got %0d expected 10", b_va); else pass_n++;
      tot_n++; if (b_vsw !== 8'd3) $display("FAIL pol_vs_width: got %0d expected 3", b_vsw); else pass_n++;
      gb = fs_n; ta0 = a_te_n; tb0 = b_te_n;
      gen_frame(121, 12, 16, 100, 16, 3, 5, 10, -1);
      for (int f = 0; f < 4; f++) frame_t2(-1);
      tot_n++; if (a_te_n - ta0 !== 1) $display("FAIL gl_err_count: got %0d expected 1", a_te_n - ta0); else pass_n++;
      tot_n++; if (a_te_last !== l1[gb] + 2) $display("FAIL gl_err_time: got %0d expected %0d", a_te_last, l1[gb] + 2); else pass_n++;
      tot_n++; if (a_lk_cyc !== fs[gb+4] + 2) $display("FAIL gl_relock_time: got %0d expected %0d", a_lk_cyc, fs[gb+4] + 2); else pass_n++;
      tot_n++; if (b_te_n - tb0 !== 1) $display("FAIL pol_err_count: got %0d expected 1", b_te_n - tb0); else pass_n++;
      tot_n++; if (b_lk_cyc !== fs[gb+4] + 2) $display("FAIL pol_relock_time: got %0d expected %0d", b_lk_cyc, fs[gb+4] + 2); else pass_n++;
   endtask

   task automatic test_watchdog();
      int base, ta0, tb0, e0;
      ta0 = a_te_n; tb0 = b_te_n; e0 = end_cyc;
      idle(400);
      tot_n++; if (b_te_n - tb0 !== 1) $display("FAIL wd_err_count: got %0d expected 1", b_te_n - tb0); else pass_n++;
      tot_n++; if (b_te_last !== e0 + 138) $display("FAIL wd_err_time: got %0d expected %0d", b_te_last, e0 + 138); else pass_n++;
      tot_n++; if (b_locked !== 1'b0) $display("FAIL wd_unlocked: got %0d expected 0", b_locked); else pass_n++;
      tot_n++; if (a_locked !== 1'b1 || a_te_n != ta0) $display("FAIL wd_wide_holds: got %0d expected 1", a_locked); else pass_n++;
      base = fs_n;
      for (int f = 0; f < 5; f++) frame_t2(-1);
      tot_n++; if (b_lk_cyc !== fs[base+3] + 2) $display("FAIL wd_relock_time: got %0d expected %0d", b_lk_cyc, fs[base+3] + 2); else pass_n++;
      tot_n++; if (b_te_n - tb0 !== 1) $display("FAIL wd_no_extra_err: got %0d expected 1", b_te_n - tb0); else pass_n++;
      tot_n++; if (a_lk_cyc !== fs[base+3] + 2) $display("FAIL wd_a_relock: got %0d expected %0d", a_lk_cyc, fs[base+3] + 2); else pass_n++;
   endtask

`ifdef VTM_ERR_COUNT_EN
   task automatic test_err_count();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(3);
      for (int f = 0; f < 4; f++) frame_t2(-1);
      for (int g = 0; g < 3; g++) begin
         frame_t2(5);
         for (int f = 0; f < 3; f++) frame_t2(-1);
         tot_n++; if (a_locked !== 1'b1) $display("FAIL ec_relock: got %0d expected 1", a_locked); else pass_n++;
      end
      tot_n++; if (a_ec !== 16'd3) $display("FAIL ec_count: got %0d expected 3", a_ec); else pass_n++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tot_n++; if (a_ec !== 16'd0) $display("FAIL ec_reset: got %0d expected 0", a_ec); else pass_n++;
      rst = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; hs_act = 1'b0; vs_act = 1'b0; de_p = 1'b0;
      test_reset();
      test_rb();
      test_reset_mid();
      test_glitch();
      test_watchdog();
`ifdef VTM_ERR_COUNT_EN
      test_err_count();
`endif
      idle(2);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule
